button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Sits directly downstream of the push-button synchronizer in the Tug of War datapath.
- Consumes the already-synchronized button level and filters mechanical bounce.
- Emits one clean single-cycle press pulse per debounced press, a debounced held level, and a wrapping press counter.
- Game control logic consumes it: one instance per player button.

Parameters:
- DEBOUNCE_CYCLES, 4, number of extra consecutive agreeing samples needed to accept a level change; legal range 1..65535.
- REPEAT_CYCLES, 10, auto-repeat period in clocks while held; used only when the optional feature is compiled in; legal minimum 2.
- CNT_W, 16, width of the internal debounce/repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- sypush, input, 1, synchronized button level from the upstream synchronizer.
- held, output, 1, debounced button level, registered.
- press_pulse, output, 1, high for exactly one clock per accepted press (or repeat), registered.
- press_count, output, 8, number of press pulses issued, modulo 256.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters=0.
  - held=0, press_pulse=0, press_count=0.
  - A reset asserted mid-debounce or mid-hold aborts immediately; no pulse is produced.
- Let D = DEBOUNCE_CYCLES. FSM states, one transition per clk edge:
  - IDLE (held=0):
    - sypush=1 -> DB_PRESS, cnt<=0.
    - else stay.
  - DB_PRESS (held=0):
    - sypush=0 -> IDLE, cnt<=0.
    - sypush=1 and cnt!=D-1 -> cnt<=cnt+1.
    - sypush=1 and cnt==D-1 -> HELD, press_pulse<=1, press_count<=press_count+1.
  - HELD (held=1):
    - sypush=0 -> DB_RELEASE, cnt<=0.
    - else stay.
  - DB_RELEASE (held=1):
    - sypush=1 -> HELD, cnt<=0, no pulse.
    - sypush=0 and cnt!=D-1 -> cnt<=cnt+1.
    - sypush=0 and cnt==D-1 -> IDLE.
- Latency:
  - A press is accepted after sypush is sampled 1 on D+1 consecutive edges.
  - press_pulse is high during the clock following the (D+1)th edge.
  - held rises in that same cycle.
  - Release is symmetric: held falls in the cycle after the (D+1)th consecutive 0 sample.
- press_pulse defaults to 0 every cycle unless set as above; it is never high for two consecutive cycles.
- press_count wraps 255 -> 0 silently.
- Any bounce (a single opposite sample) in a DB_* state restarts from the stable state it left. The counter never saturates or overflows.
- held changes only on the IDLE/DB_PRESS -> HELD and DB_RELEASE -> IDLE transitions.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter rcnt increments every cycle.
  - When rcnt==REPEAT_CYCLES-1, press_pulse<=1, press_count increments, and rcnt<=0.
  - rcnt is cleared on entry to HELD, including a bounce return from DB_RELEASE.
  - rcnt holds in DB_RELEASE.
  - The first repeat pulse follows the initial pulse by exactly REPEAT_CYCLES clocks.
- Undefined:
  - No repeat counter is instantiated; REPEAT_CYCLES is ignored.
  - Exactly one pulse per press.

Decomposition:
- Shared package (game_pkg) holds:
  - state encoding localparams: IDLE=2'd0, DB_PRESS=2'd1, HELD=2'd2, DB_RELEASE=2'd3;
  - the press_count width constant (8);
  - a clog2 function for counter sizing.
- One natural sub-module, cycle_counter:
  - clear/enable inputs, CNT_W-bit count, terminal flag at a parameterised limit-1;
  - instantiated for the debounce count, and again for repeat when the macro is on.

Test Plan (D=4, REPEAT_CYCLES=10):
- Clean press: sypush 0->1 held 20 clocks -> press_pulse high exactly one cycle, 5 edges after the first high sample; held=1; press_count=1.
- Bounce: sypush pattern 1,1,0,1,1,1,1,1 -> the pulse only after the last five consecutive 1s, one pulse total; a 1,0,1,0 chatter pattern -> no pulse, held=0.
- Release bounce: while HELD, sypush 0,0,1 then steady 1 -> held stays 1, no extra pulse; then 5 consecutive 0s -> held=0.
- Wrap: 256 clean presses -> press_count reads 0; 257 presses -> 1.
- Async reset: drop rst mid-DB_PRESS and mid-HELD -> outputs 0 immediately, without waiting for clk; after release, the next press needs the full D+1 samples.
- With BUTTON_DEBOUNCER_AUTO_REPEAT_EN, hold 35 clocks past acceptance -> pulses at +0, +10, +20, +30; press_count=4. Without the macro -> 1 pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the Tug of War button path: FSM state encoding,
// press counter width and a clog2 helper for sizing counters.
package game_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    localparam int PRESS_CNT_W = 8;

    // Number of bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between the button synchronizer/game logic and one debouncer.
// Also carries the debouncer's FSM state and counters for observation.
interface button_debouncer_if #(
    parameter int CNT_W = 16
);
    import game_pkg::*;

    // Level/strobe interface, no handshake: sypush is sampled on every rising
    // clock edge with no valid qualifier; press_pulse is a one-cycle strobe
    // that the consumer must take in the cycle it is high (no backpressure).
    logic                   sypush;
    logic                   held;
    logic                   press_pulse;
    logic [PRESS_CNT_W-1:0] press_count;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       rcnt;

    modport master (
        output sypush,
        input  held, press_pulse, press_count, state, cnt, rcnt
    );

    modport slave (
        input  sypush,
        output held, press_pulse, press_count, state, cnt, rcnt
    );

endinterface

// File: rtl/cycle_counter.sv
// Clearable, enabled up-counter with a terminal flag at LIMIT-1.
// Clear has priority over enable.
module cycle_counter #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // Count register: clear wins, otherwise advance when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal flag marks the last count of the period.
    always_comb begin
        done = (count == CNT_W'(LIMIT - 1));
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: filters bounce on a synchronized button level and
// produces a debounced level, a one-cycle press pulse and a wrapping press
// count. Optional auto-repeat while held is enabled with the macro
// BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 10,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    button_debouncer_if.slave  bus
);
    import game_pkg::*;

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic                   sample;
    logic                   agree;
    logic                   db_clear;
    logic                   db_done;
    logic [CNT_W-1:0]       db_cnt;
    logic                   accept;
    logic                   rep_fire;
    logic                   pulse_set;
    logic                   next_held;
    logic                   held_q;
    logic                   pulse_q;
    logic [PRESS_CNT_W-1:0] count_q;

    assign sample = bus.sypush;

    // A sample "agrees" when it confirms the change being debounced.
    always_comb begin
        agree = ((state == DB_PRESS) && sample) ||
                ((state == DB_RELEASE) && !sample);
    end

    // Debounce counter restarts on any opposite sample and after it expires.
    always_comb begin
        db_clear = !agree || db_done;
    end

    cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (DEBOUNCE_CYCLES)
    ) u_db_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (db_clear),
        .enable (agree),
        .count  (db_cnt),
        .done   (db_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sample) next_state = DB_PRESS;
            end
            DB_PRESS: begin
                if (!sample)      next_state = IDLE;
                else if (db_done) next_state = HELD;
            end
            HELD: begin
                if (!sample) next_state = DB_RELEASE;
            end
            DB_RELEASE: begin
                if (sample)       next_state = HELD;
                else if (db_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    logic             in_held;
    logic             enter_held;
    logic             rep_clear;
    logic             rep_done;
    logic [CNT_W-1:0] rcnt;

    // Repeat counter runs only in HELD, restarts on every entry to HELD and
    // after each repeat, and freezes in DB_RELEASE.
    always_comb begin
        in_held    = (state == HELD);
        enter_held = (next_state == HELD) && (state != HELD);
        rep_clear  = enter_held || (in_held && rep_done);
        rep_fire   = in_held && rep_done;
    end

    cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (REPEAT_CYCLES)
    ) u_rep_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (rep_clear),
        .enable (in_held),
        .count  (rcnt),
        .done   (rep_done)
    );

    assign bus.rcnt = rcnt;
`else
    logic unused_repeat;

    // Without auto-repeat there is exactly one pulse per press.
    always_comb begin
        rep_fire = 1'b0;
    end

    assign unused_repeat = (REPEAT_CYCLES > 1);
    assign bus.rcnt      = '0;
`endif

    // FSM outputs: press acceptance, pulse request and next debounced level.
    always_comb begin
        accept    = (state == DB_PRESS) && sample && db_done;
        pulse_set = accept || rep_fire;
        next_held = (next_state == HELD) || (next_state == DB_RELEASE);
    end

    // Registered outputs; reset aborts any pending press without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q  <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            held_q  <= next_held;
            pulse_q <= pulse_set;
            if (pulse_set) count_q <= count_q + PRESS_CNT_W'(1);
        end
    end

    assign bus.held        = held_q;
    assign bus.press_pulse = pulse_q;
    assign bus.press_count = count_q;
    assign bus.state       = state;
    assign bus.cnt         = db_cnt;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer. Honors
// BUTTON_DEBOUNCER_AUTO_REPEAT_EN for repeat-dependent expectations.
module tb_button_debouncer;
    import game_pkg::*;

    localparam int D = 4;
    localparam int R = 10;
    localparam int W = 10;

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    localparam int EXP_CLEAN_PULSES  = 2;
    localparam int EXP_REPEAT_PULSES = 4;
`else
    localparam int EXP_CLEAN_PULSES  = 1;
    localparam int EXP_REPEAT_PULSES = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    button_debouncer_if bus();

    button_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R),
        .CNT_W           (16)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Debounced level flips once D+1 consecutive samples disagree with it.
    logic [W-1:0] exp_q[$];
    int       run_m;
    int       run_before;
    int       rep_m;
    bit       held_m;
    bit       held_before;
    bit       fire_m;
    bit       s_m;
    bit [7:0] cnt_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_m  = 0;
            rep_m  = 0;
            held_m = 1'b0;
            cnt_m  = 8'd0;
            exp_q.delete();
        end else begin
            s_m         = bus.sypush;
            run_before  = run_m;
            held_before = held_m;
            fire_m      = 1'b0;
            if (s_m != held_m) run_m = run_m + 1;
            else               run_m = 0;
            if (run_m == D + 1) begin
                held_m = s_m;
                run_m  = 0;
                rep_m  = 0;
                if (s_m) fire_m = 1'b1;
            end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
            if (held_before && run_before == 0) begin
                rep_m = rep_m + 1;
                if (rep_m == R) begin
                    fire_m = 1'b1;
                    rep_m  = 0;
                end
            end else if (held_before && run_before > 0 && s_m) begin
                rep_m = 0;
            end
`endif
            if (fire_m) cnt_m = cnt_m + 8'd1;
            exp_q.push_back({held_m, fire_m, cnt_m});
        end
    end

    // ---------------- scoreboard compare ----------------
    logic [W-1:0] exp_v;
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("sb_held",  32'(bus.held),        32'(exp_v[9]));
            check("sb_pulse", 32'(bus.press_pulse), 32'(exp_v[8]));
            check("sb_count", 32'(bus.press_count), 32'(exp_v[7:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit v);
        bus.sypush = v;
        @(posedge clk);
        @(negedge clk);
        if (bus.press_pulse) pulses++;
    endtask

    task automatic steps(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.sypush = 1'b0;
        #1;
        check("rst_held",  32'(bus.held),        32'd0);
        check("rst_pulse", 32'(bus.press_pulse), 32'd0);
        check("rst_count", 32'(bus.press_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int p0;
    bit lvl;
    int len;

    initial begin
        bus.sypush = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("init_held",  32'(bus.held),        32'd0);
        check("init_pulse", 32'(bus.press_pulse), 32'd0);
        check("init_count", 32'(bus.press_count), 32'd0);
        rst_n = 1'b1;
        steps(1'b0, 3);

        // Clean press: pulse on the 5th high sample, not before.
        p0 = pulses;
        for (int i = 0; i < D; i++) begin
            step(1'b1);
            check("clean_early_pulse", 32'(bus.press_pulse), 32'd0);
        end
        step(1'b1);
        check("clean_pulse", 32'(bus.press_pulse), 32'd1);
        check("clean_held",  32'(bus.held),        32'd1);
        check("clean_count", 32'(bus.press_count), 32'd1);
        steps(1'b1, 15);
        check("clean_pulses", 32'(pulses - p0), 32'(EXP_CLEAN_PULSES));
        steps(1'b0, D);
        check("release_early_held", 32'(bus.held), 32'd1);
        step(1'b0);
        check("release_held", 32'(bus.held), 32'd0);
        steps(1'b0, 2);

        // Bounce during press: 1,1,0 then five 1s.
        p0 = pulses;
        step(1'b1); step(1'b1); step(1'b0);
        steps(1'b1, D);
        check("bounce_no_early", 32'(pulses - p0), 32'd0);
        step(1'b1);
        check("bounce_pulse",  32'(bus.press_pulse), 32'd1);
        check("bounce_pulses", 32'(pulses - p0),     32'd1);
        steps(1'b0, D + 3);

        // Chatter never reaches acceptance.
        p0 = pulses;
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        check("chatter_pulses", 32'(pulses - p0), 32'd0);
        check("chatter_held",   32'(bus.held),    32'd0);
        steps(1'b0, 2);

        // Release bounce while held.
        steps(1'b1, D + 1);
        p0 = pulses;
        step(1'b0); step(1'b0); step(1'b1);
        steps(1'b1, 6);
        check("relbounce_held",   32'(bus.held),    32'd1);
        check("relbounce_pulses", 32'(pulses - p0), 32'd0);
        steps(1'b0, D + 1);
        check("relbounce_release", 32'(bus.held), 32'd0);
        steps(1'b0, 2);

        // Long hold: auto-repeat pulses when compiled in.
        p0 = pulses;
        steps(1'b1, D + 1 + 35);
        check("repeat_pulses", 32'(pulses - p0), 32'(EXP_REPEAT_PULSES));
        steps(1'b0, D + 3);

        // Async reset mid-DB_PRESS, then mid-HELD.
        steps(1'b1, 2);
        do_reset();
        steps(1'b1, D + 3);
        do_reset();
        for (int i = 0; i < D; i++) begin
            step(1'b1);
            check("post_rst_early", 32'(bus.press_pulse), 32'd0);
        end
        step(1'b1);
        check("post_rst_pulse", 32'(bus.press_pulse), 32'd1);
        check("post_rst_count", 32'(bus.press_count), 32'd1);
        steps(1'b0, D + 3);

        // Randomized bursts including bounce-length and long runs.
        for (int i = 0; i < 300; i++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 25) : $urandom_range(1, 6);
            steps(lvl, len);
        end
        steps(1'b0, D + 3);

        // Counter wrap from a known zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            steps(1'b1, D + 1);
            steps(1'b0, D + 1);
        end
        check("wrap_256", 32'(bus.press_count), 32'd0);
        steps(1'b1, D + 1);
        steps(1'b0, D + 1);
        check("wrap_257", 32'(bus.press_count), 32'd1);

        steps(1'b0, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
